// File: rtl/lcd_par_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | lcd_par_pkg : shared offsets, engine states and FIFO entry layout |
// | Revision    : 1.0                                                 |
// +------------------------------------------------------------------+
package lcd_par_pkg;

   localparam logic [7:0] OFF_DATA   = 8'h00;
   localparam logic [7:0] OFF_FILL   = 8'h04;
   localparam logic [7:0] OFF_DC     = 8'h08;
   localparam logic [7:0] OFF_NRST   = 8'h0C;
   localparam logic [7:0] OFF_STATUS = 8'h10;

   localparam int DATA_W = 16;
   localparam int CNT_W  = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_LOW  = 2'd2,
      ST_HIGH = 2'd3
   } eng_state_e;

   typedef struct packed {
      logic              dc;
      logic              fill;
      logic [CNT_W-1:0]  count;
      logic [DATA_W-1:0] data;
   } fifo_entry_t;

   localparam int ENTRY_W = $bits(fifo_entry_t);

   // First beat of a pixel: on an 8-bit bus a FILL pixel starts with its high byte.
   function automatic logic [DATA_W-1:0] first_beat(input logic fill,
                                                    input logic [DATA_W-1:0] data,
                                                    input int bus_w);
      if (bus_w == 8 && fill) return {8'h00, data[15:8]};
      if (bus_w == 8)         return {8'h00, data[7:0]};
      return data;
   endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_par_fifo.sv
`default_nettype none
// +------------------------------------------------------------------+
// | lcd_par_fifo : synchronous show-ahead FIFO with full/empty/level  |
// | Revision     : 1.0                                                |
// +------------------------------------------------------------------+
module lcd_par_fifo #(
   parameter  int WIDTH = 34,
   parameter  int DEPTH = 16,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic [AW:0]      level
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      level_q, level_d;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop)      level_d = level_q + 1'b1;
      else if (pop && !push) level_d = level_q - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= din;
   end

   assign dout  = mem_q[rd_ptr_q];
   assign level = level_q;
   assign empty = (level_q == '0);
   assign full  = (level_q == (AW+1)'(DEPTH));

endmodule
`default_nettype wire

// File: rtl/lcd_par_writer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | lcd_par_writer : memory-mapped command queue driving an 8080-style |
// |                  parallel LCD write interface                      |
// | Revision       : 1.0                                               |
// +------------------------------------------------------------------+
module lcd_par_writer
   import lcd_par_pkg::*;
#(
   parameter int BUS_W      = 8,
   parameter int FIFO_DEPTH = 16,
   parameter int WR_LOW     = 1,
   parameter int WR_HIGH    = 1
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             iomem_valid,
   output logic             iomem_ready,
   input  logic [3:0]       iomem_wstrb,
   input  logic [31:0]      iomem_addr,
   input  logic [31:0]      iomem_wdata,
   output logic [31:0]      iomem_rdata,
   output logic             nreset,
   output logic             cmd_data,
   output logic             write_edge,
   output logic [BUS_W-1:0] dout
);

   localparam int          LVL_W    = $clog2(FIFO_DEPTH) + 1;
   localparam logic [15:0] TMR_LOW  = 16'(WR_LOW - 1);
   localparam logic [15:0] TMR_HIGH = 16'(WR_HIGH - 1);

   logic              ready_q, ready_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              nreset_q, nreset_d;
   logic              dc_q, dc_d;

   fifo_entry_t       push_entry, fifo_out;
   logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [LVL_W-1:0]  fifo_level;

   eng_state_e        state_q;
   logic              cur_fill_q;
   logic [DATA_W-1:0] cur_data_q;
   logic [CNT_W-1:0]  pix_q;
   logic              beat_q;
   logic [15:0]       tmr_q;
   logic              write_edge_q, cmd_data_q;
   logic [BUS_W-1:0]  dout_q;

   logic [7:0]        off;
   logic              is_wr, is_push, accept, busy, two_beat;
   logic              unused_addr;

   assign unused_addr = ^iomem_addr[31:8];
   assign off         = iomem_addr[7:0];
   assign is_wr       = |iomem_wstrb;
   assign busy        = (state_q != ST_IDLE) || !fifo_empty;
   assign fifo_pop    = (state_q == ST_LOAD);
   assign two_beat    = cur_fill_q && (BUS_W == 8);

   // A full FIFO still accepts when the engine pops in the same cycle.
   always_comb begin
      is_push          = is_wr && (off == OFF_DATA || off == OFF_FILL);
      accept           = iomem_valid && !ready_q && (!is_push || !fifo_full || fifo_pop);
      fifo_push        = accept && is_push;
      push_entry.dc    = dc_q;
      push_entry.fill  = (off == OFF_FILL);
      push_entry.count = (off == OFF_FILL) ? iomem_wdata[31:16] : 16'd1;
      push_entry.data  = iomem_wdata[15:0];
      ready_d          = accept;
      rdata_d          = '0;
      nreset_d         = nreset_q;
      dc_d             = dc_q;
      if (accept && is_wr && off == OFF_DC)   dc_d     = iomem_wdata[0];
      if (accept && is_wr && off == OFF_NRST) nreset_d = iomem_wdata[0];
      if (accept && !is_wr && off == OFF_STATUS)
         rdata_d = {16'h0000, 8'(fifo_level), 6'b000000, fifo_full, busy};
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         ready_q  <= 1'b0;
         rdata_q  <= '0;
         nreset_q <= 1'b1;
         dc_q     <= 1'b0;
      end else begin
         ready_q  <= ready_d;
         rdata_q  <= rdata_d;
         nreset_q <= nreset_d;
         dc_q     <= dc_d;
      end
   end

   lcd_par_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk    (clk),
      .resetn (resetn),
      .push   (fifo_push),
      .din    (push_entry),
      .pop    (fifo_pop),
      .dout   (fifo_out),
      .full   (fifo_full),
      .empty  (fifo_empty),
      .level  (fifo_level)
   );

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q      <= ST_IDLE;
         cur_fill_q   <= 1'b0;
         cur_data_q   <= '0;
         pix_q        <= '0;
         beat_q       <= 1'b0;
         tmr_q        <= '0;
         write_edge_q <= 1'b0;
         cmd_data_q   <= 1'b0;
         dout_q       <= '0;
      end else begin
         case (state_q)
            ST_IDLE: if (!fifo_empty) state_q <= ST_LOAD;
            ST_LOAD: begin
               cmd_data_q <= fifo_out.dc;
               cur_fill_q <= fifo_out.fill;
               cur_data_q <= fifo_out.data;
               beat_q     <= 1'b0;
               if (fifo_out.count == '0) begin
                  state_q <= ST_IDLE;
               end else begin
                  pix_q   <= fifo_out.count - 1'b1;
                  dout_q  <= BUS_W'(first_beat(fifo_out.fill, fifo_out.data, BUS_W));
                  tmr_q   <= TMR_LOW;
                  state_q <= ST_LOW;
               end
            end
            ST_LOW: begin
               if (tmr_q == '0) begin
                  write_edge_q <= 1'b1;
                  tmr_q        <= TMR_HIGH;
                  state_q      <= ST_HIGH;
               end else begin
                  tmr_q <= tmr_q - 1'b1;
               end
            end
            ST_HIGH: begin
               if (tmr_q != '0) begin
                  tmr_q <= tmr_q - 1'b1;
               end else begin
                  write_edge_q <= 1'b0;
                  if (two_beat && !beat_q) begin
                     beat_q  <= 1'b1;
                     dout_q  <= BUS_W'(cur_data_q[7:0]);
                     tmr_q   <= TMR_LOW;
                     state_q <= ST_LOW;
                  end else if (pix_q != '0) begin
                     pix_q   <= pix_q - 1'b1;
                     beat_q  <= 1'b0;
                     dout_q  <= BUS_W'(first_beat(cur_fill_q, cur_data_q, BUS_W));
                     tmr_q   <= TMR_LOW;
                     state_q <= ST_LOW;
                  end else if (!fifo_empty) begin
                     state_q <= ST_LOAD;
                  end else begin
                     state_q <= ST_IDLE;
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign iomem_ready = ready_q;
   assign iomem_rdata = rdata_q;
   assign nreset      = nreset_q;
   assign cmd_data    = cmd_data_q;
   assign write_edge  = write_edge_q;
   assign dout        = dout_q;

endmodule
`default_nettype wire

// File: tb/tb_lcd_par_writer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_lcd_par_writer : directed bench, default and 16-bit instances |
// | Revision          : 1.0                                          |
// +------------------------------------------------------------------+
module tb_lcd_par_writer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int cyc_cnt  = 0;
   always @(posedge clk) cyc_cnt++;

   // Instance A: defaults. Instance B: 16-bit bus, 4-deep FIFO, 2/1 strobe.
   logic        resetn_a = 1'b0, resetn_b = 1'b0;
   logic        valid_a = 1'b0, valid_b = 1'b0;
   logic [3:0]  wstrb_a = '0, wstrb_b = '0;
   logic [31:0] addr_a = '0, addr_b = '0, wdata_a = '0, wdata_b = '0;
   logic        rdy_a, rdy_b, nrst_a, nrst_b, cd_a, cd_b, we_a, we_b;
   logic [31:0] rdata_a, rdata_b;
   logic [7:0]  dout_a;
   logic [15:0] dout_b;

   lcd_par_writer u_dut_a (
      .clk(clk), .resetn(resetn_a), .iomem_valid(valid_a), .iomem_ready(rdy_a),
      .iomem_wstrb(wstrb_a), .iomem_addr(addr_a), .iomem_wdata(wdata_a),
      .iomem_rdata(rdata_a), .nreset(nrst_a), .cmd_data(cd_a),
      .write_edge(we_a), .dout(dout_a)
   );

   lcd_par_writer #(.BUS_W(16), .FIFO_DEPTH(4), .WR_LOW(2), .WR_HIGH(1)) u_dut_b (
      .clk(clk), .resetn(resetn_b), .iomem_valid(valid_b), .iomem_ready(rdy_b),
      .iomem_wstrb(wstrb_b), .iomem_addr(addr_b), .iomem_wdata(wdata_b),
      .iomem_rdata(rdata_b), .nreset(nrst_b), .cmd_data(cd_b),
      .write_edge(we_b), .dout(dout_b)
   );

   logic [15:0] ea_d[$], eb_d[$];
   bit          ea_c[$], eb_c[$];
   int          ea_t[$], eb_t[$];
   int          viol_hold = 0, viol_rdy = 0;
   logic        pwe_a = 0, pwe_b = 0, pcd_a = 0, pcd_b = 0, prdy_a = 0, prdy_b = 0;
   logic [7:0]  pd_a = 0;
   logic [15:0] pd_b = 0;

   // Records every rising write_edge and flags outputs moving while it is high.
   always @(negedge clk) begin
      if (we_a && !pwe_a) begin ea_d.push_back(16'(dout_a)); ea_c.push_back(cd_a); ea_t.push_back(cyc_cnt); end
      if (we_b && !pwe_b) begin eb_d.push_back(dout_b); eb_c.push_back(cd_b); eb_t.push_back(cyc_cnt); end
      if (we_a && pwe_a && (dout_a != pd_a || cd_a != pcd_a)) viol_hold++;
      if (we_b && pwe_b && (dout_b != pd_b || cd_b != pcd_b)) viol_hold++;
      if ((rdy_a && prdy_a) || (rdy_b && prdy_b)) viol_rdy++;
      pwe_a = we_a; pwe_b = we_b; pcd_a = cd_a; pcd_b = cd_b;
      pd_a = dout_a; pd_b = dout_b; prdy_a = rdy_a; prdy_b = rdy_b;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic bus(input bit sel, input logic [31:0] addr, input logic [31:0] wdata,
                      input bit wr, output logic [31:0] rdata, output int cyc);
      @(negedge clk);
      if (sel) begin valid_b = 1; addr_b = addr; wdata_b = wdata; wstrb_b = wr ? 4'hF : 4'h0; end
      else     begin valid_a = 1; addr_a = addr; wdata_a = wdata; wstrb_a = wr ? 4'hF : 4'h0; end
      cyc   = 0;
      rdata = '0;
      forever begin
         @(negedge clk);
         cyc++;
         if ((sel ? rdy_b : rdy_a) === 1'b1) begin
            rdata = sel ? rdata_b : rdata_a;
            break;
         end
         if (cyc >= 2000) begin
            checks++; failures++;
            $error("FAIL bus_timeout: observed=%0d cycles expected=ready", cyc);
            break;
         end
      end
      if (sel) valid_b = 0; else valid_a = 0;
   endtask

   task automatic wait_idle(input bit sel);
      logic [31:0] rd;
      int          c;
      for (int i = 0; i < 1000; i++) begin
         bus(sel, 32'h10, 32'h0, 1'b0, rd, c);
         if (rd[0] == 1'b0) return;
      end
      checks++; failures++;
      $error("FAIL idle_timeout: observed=busy expected=idle");
   endtask

   logic [31:0] rd;
   int          c, base, n0;
   logic [15:0] exp6[6];

   initial begin
      repeat (3) @(negedge clk);
      resetn_a = 1; resetn_b = 1;
      @(negedge clk);
      chk("rst_ready", {31'h0, rdy_a}, 32'h0);
      chk("rst_rdata", rdata_a, 32'h0);
      chk("rst_nreset", {31'h0, nrst_a}, 32'h1);
      chk("rst_cmd_data", {31'h0, cd_a}, 32'h0);
      chk("rst_write_edge", {31'h0, we_a}, 32'h0);
      chk("rst_dout", {24'h0, dout_a}, 32'h0);
      bus(0, 32'h10, 0, 0, rd, c);
      chk("rst_status", rd, 32'h0);

      // Single DATA command byte
      bus(0, 32'h08, 32'h0, 1, rd, c);
      chk("dc_ack_latency", c, 1);
      base = ea_d.size();
      bus(0, 32'h00, 32'h2A, 1, rd, c);
      wait_idle(0);
      chk("data_edges", ea_d.size() - base, 1);
      chk("data_dout", {16'h0, ea_d[base]}, 32'h2A);
      chk("data_cmd", {31'h0, ea_c[base]}, 32'h0);

      // 8-bit FILL, 3 pixels of 0xF800 as data
      bus(0, 32'h08, 32'h1, 1, rd, c);
      base = ea_d.size();
      bus(0, 32'h04, 32'h0003_F800, 1, rd, c);
      wait_idle(0);
      chk("fill8_edges", ea_d.size() - base, 6);
      for (int i = 0; i < 6; i++) begin
         chk($sformatf("fill8_dout%0d", i), {16'h0, ea_d[base+i]}, (i % 2 == 0) ? 32'hF8 : 32'h00);
         chk($sformatf("fill8_cmd%0d", i), {31'h0, ea_c[base+i]}, 32'h1);
         if (i > 0) chk($sformatf("fill8_gap%0d", i), ea_t[base+i] - ea_t[base+i-1], 2);
      end

      // DC change must not retag entries already queued
      base = ea_d.size();
      bus(0, 32'h04, 32'h000A_0102, 1, rd, c);
      bus(0, 32'h00, 32'h11, 1, rd, c);
      bus(0, 32'h08, 32'h0, 1, rd, c);
      bus(0, 32'h00, 32'h22, 1, rd, c);
      wait_idle(0);
      chk("dcq_edges", ea_d.size() - base, 22);
      chk("dcq_dout_a", {16'h0, ea_d[base+20]}, 32'h11);
      chk("dcq_cmd_a", {31'h0, ea_c[base+20]}, 32'h1);
      chk("dcq_dout_b", {16'h0, ea_d[base+21]}, 32'h22);
      chk("dcq_cmd_b", {31'h0, ea_c[base+21]}, 32'h0);

      // Panel reset register, unmapped offset
      bus(0, 32'h0C, 32'h0, 1, rd, c);
      chk("nrst_low", {31'h0, nrst_a}, 32'h0);
      bus(0, 32'h0C, 32'h1, 1, rd, c);
      chk("nrst_high", {31'h0, nrst_a}, 32'h1);
      bus(0, 32'h20, 32'h0, 0, rd, c);
      chk("unmapped_rdata", rd, 32'h0);
      chk("unmapped_latency", c, 1);

      // FILL with count 0
      base = ea_d.size();
      bus(0, 32'h04, 32'h0000_00FF, 1, rd, c);
      chk("fill0_latency", c, 1);
      repeat (5) @(negedge clk);
      bus(0, 32'h10, 0, 0, rd, c);
      chk("fill0_status", rd, 32'h0);
      chk("fill0_edges", ea_d.size() - base, 0);

      // Level/busy, then reset during a HIGH phase of a 100-pixel fill
      bus(0, 32'h04, 32'h0064_ABCD, 1, rd, c);
      bus(0, 32'h00, 32'h01, 1, rd, c);
      bus(0, 32'h00, 32'h02, 1, rd, c);
      bus(0, 32'h00, 32'h03, 1, rd, c);
      bus(0, 32'h10, 0, 0, rd, c);
      chk("status_level3", rd, 32'h0000_0301);
      for (int i = 0; i < 50 && !we_a; i++) @(negedge clk);
      chk("pre_rst_high", {31'h0, we_a}, 32'h1);
      resetn_a = 0;
      @(negedge clk);
      chk("rst_we_next", {31'h0, we_a}, 32'h0);
      n0 = ea_d.size();
      repeat (3) @(negedge clk);
      resetn_a = 1;
      repeat (3) @(negedge clk);
      chk("rst_no_edges", ea_d.size() - n0, 0);
      bus(0, 32'h10, 0, 0, rd, c);
      chk("rst_status_after", rd, 32'h0);
      chk("rst_dout_after", {24'h0, dout_a}, 32'h0);

      // 16-bit bus, 2/1 strobe
      base = eb_d.size();
      bus(1, 32'h04, 32'h0002_1234, 1, rd, c);
      wait_idle(1);
      chk("fill16_edges", eb_d.size() - base, 2);
      chk("fill16_dout0", {16'h0, eb_d[base]}, 32'h1234);
      chk("fill16_dout1", {16'h0, eb_d[base+1]}, 32'h1234);
      chk("fill16_gap", eb_t[base+1] - eb_t[base], 3);

      // Back-pressure on the 4-deep FIFO behind a long fill
      base = eb_d.size();
      bus(1, 32'h04, 32'h0014_BEEF, 1, rd, c);
      repeat (4) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         bus(1, 32'h00, 32'h0101 * (i + 1), 1, rd, c);
         chk($sformatf("ff_wr%0d_latency", i), c, 1);
      end
      bus(1, 32'h10, 0, 0, rd, c);
      chk("ff_status_full", rd, 32'h0000_0403);
      bus(1, 32'h00, 32'h0505, 1, rd, c);
      chk("ff_wr5_stalled", {31'h0, (c > 10)}, 32'h1);
      bus(1, 32'h00, 32'h0606, 1, rd, c);
      wait_idle(1);
      chk("ff_edges", eb_d.size() - base, 26);
      exp6 = '{16'h0101, 16'h0202, 16'h0303, 16'h0404, 16'h0505, 16'h0606};
      for (int i = 0; i < 6; i++)
         chk($sformatf("ff_order%0d", i), {16'h0, eb_d[base+20+i]}, {16'h0, exp6[i]});

      chk("hold_while_high", viol_hold, 0);
      chk("ready_single_pulse", viol_rdy, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
